irq_ctrl4: RTL and testbench
============================

# irq_ctrl4

Four-source interrupt request controller that sits directly upstream of the team's 4-to-2 priority encoder stage. It captures rising edges on four request lines into sticky pending bits and applies a per-source mask. The masked pending vector drives a 4-to-2 priority encoder, and the controller presents the winning source index over a valid/ack handshake. Lost requests (edges arriving while the same source is still pending) are counted for debug.

## Interface
- `CNT_W`, default 8: width of the saturating lost-request counter.

- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: request lines, synchronous to `clk`; a 0→1 transition is one request.
- `mask` input 4: `mask[i]=1` blocks source i from presentation; its pending bit is kept.
- `ack` input 1: consumer accepts the presented interrupt; only meaningful while `irq_valid=1`.
- `irq_valid` output 1: an interrupt id is being presented.
- `irq_id` output 2: index of the presented source; stable while `irq_valid=1`.
- `pending` output 4: current sticky pending bits, unmasked view.
- `lost_cnt` output CNT_W: saturating count of dropped request edges.

## Operation
- Edge detect: `req_q` is a registered copy of `req`; `rise = req & ~req_q`.
- On each clock, `pending[i]` is set when `rise[i]=1`.
- `pending[i]` is cleared when the presented id equals i and an ack is accepted.
- If a set and a clear of the same bit happen in one cycle, the set wins.
- Lost request: `rise[i]=1` while `pending[i]=1` and no clear of bit i that cycle. This increments `lost_cnt` by 1, saturating at all-ones.
- Multiple lost requests in one cycle still add only 1.
- Priority: `cand = pending & ~mask`. Bit 3 has the highest priority and bit 0 the lowest. The encoder output is the index of the highest set bit of `cand`.
- State machine, three states:
  - IDLE: `irq_valid=0`. If `cand≠0`, latch the encoder output into `irq_id` and go to PRESENT.
  - PRESENT: `irq_valid=1`, `irq_id` frozen. There is no preemption: a higher-priority arrival waits. Masking or clearing the presented source does not retract it. When `ack=1`, clear `pending[irq_id]` and go to GAP.
  - GAP: `irq_valid=0` for exactly one cycle, then go to IDLE. The `ack` input is ignored here.
- `ack` asserted in IDLE or GAP has no effect.
- `irq_id` keeps its last value when `irq_valid=0`.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - state = IDLE
  - `req_q=0`, `pending=0`, `lost_cnt=0`
  - `irq_valid=0`, `irq_id=2'b00`
- A `req` line already high at reset release counts as an edge on the first clock.
- Request to presentation latency is 2 clocks. `req[i]` first sampled high at edge k gives `pending[i]=1` after edge k and `irq_valid=1` after edge k+1, provided the controller is in IDLE and the source is unmasked.
- Ack accepted at edge m gives `irq_valid=0` and `pending[irq_id]` cleared after edge m.
- The earliest next `irq_valid=1` is after edge m+2, so the minimum spacing between grants is 3 cycles.
- Mask changes take effect on the same edge as the IDLE evaluation, with no extra register delay.
- Reset asserted mid-handshake returns everything to reset values immediately. A pending request is lost and not counted.

## Structure
- The shared package holds the state encoding constants (IDLE, PRESENT, GAP) and the source-count constant 4.
- One sub-module, `pri_enc4`: a combinational 4-to-2 priority encoder, highest bit wins, output `2'b00` for zero input.
  - `cand` drives it.
  - The top level holds `req_q`, `pending`, the FSM and `lost_cnt`.

## Test plan
- Reset, then a single pulse on `req=4'b0100`, `mask=0`:
  - `pending=4'b0100` one clock later.
  - `irq_valid=1, irq_id=2'b10` the clock after.
  - `ack` pulse gives `pending=0` and `irq_valid=0` for 1 cycle.
- Simultaneous rise on `req=4'b1011`:
  - Presentation order is id 3, then 1, then 0, with one GAP cycle between grants.
  - `pending` goes `1011→0011→0001→0000`.
- `mask=4'b1000` with `req=4'b1001`:
  - id 0 is presented.
  - After ack, with `pending=4'b1000` still set, `irq_valid` stays 0.
  - Clearing the mask gives id 3 presented 1 cycle later.
- No preemption:
  - While id 1 is presented, `req[3]` rises.
  - `irq_id` stays `2'b01` until ack, and id 3 follows after the GAP cycle.
- Lost count:
  - Pulse `req[2]` three times, never acking, and mask source 2.
  - Expect `lost_cnt=2`.
  - With `CNT_W=2`, six extra pulses saturate it at 3.
  - A set during the ack-clear cycle keeps the bit set and is not counted.
- Reset mid-PRESENT:
  - Assert `rst_n=0` while `irq_valid=1`.
  - All outputs return to their reset values immediately, before the next clock edge.
  - With `req` held high through the release, `pending` re-sets on the first clock.

Source files
------------

// File: rtl/irq_ctrl4_pkg.sv
// irq_ctrl4_pkg: shared constants and types for the four-source interrupt
// controller. Holds the source count, id width, FSM state encoding and a
// small helper that turns a source id into a one-hot clear mask.
package irq_ctrl4_pkg;

    localparam int NSRC = 4;
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    // One-hot mask selecting the pending bit that belongs to source id.
    function automatic logic [NSRC-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/irq_ctrl4_if.sv
// irq_ctrl4_if: request/handshake bundle between an interrupt consumer
// (master) and irq_ctrl4 (slave).
//   req, mask, ack          : consumer -> controller
//   irq_valid, irq_id,
//   pending                 : controller -> consumer
interface irq_ctrl4_if;
    import irq_ctrl4_pkg::*;

    logic [NSRC-1:0] req;
    logic [NSRC-1:0] mask;
    logic            ack;
    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic [NSRC-1:0] pending;

    modport master (
        output req, mask, ack,
        input  irq_valid, irq_id, pending
    );

    modport slave (
        input  req, mask, ack,
        output irq_valid, irq_id, pending
    );
endinterface

// File: rtl/irq_ctrl4_pri_enc4.sv
// pri_enc4: combinational 4-to-2 priority encoder. Bit 3 has the highest
// priority. An all-zero input yields 2'b00.
//   cand : input 4, candidate vector
//   id   : output 2, index of the highest set bit
module pri_enc4
    import irq_ctrl4_pkg::*;
(
    input  logic [NSRC-1:0] cand,
    output logic [ID_W-1:0] id
);

    // Highest set bit wins.
    always_comb begin
        id = 2'b00;
        if (cand[3]) begin
            id = 2'b11;
        end else if (cand[2]) begin
            id = 2'b10;
        end else if (cand[1]) begin
            id = 2'b01;
        end else begin
            id = 2'b00;
        end
    end

endmodule

// File: rtl/irq_ctrl4.sv
// irq_ctrl4: four-source interrupt controller. Rising edges on bus.req set
// sticky pending bits. The masked pending vector is priority-encoded, and the
// winner is presented over a valid/ack handshake. Each grant is followed by
// one idle gap cycle. Edges that hit an already-pending source are counted in
// a saturating debug counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : irq_ctrl4_if.slave (req, mask, ack in; irq_valid, irq_id, pending out)
//   lost_cnt   : output CNT_W, saturating count of dropped request edges
module irq_ctrl4
    import irq_ctrl4_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_ctrl4_if.slave       bus,
    output logic [CNT_W-1:0] lost_cnt
);

    state_t          state_r, state_nxt_s;
    logic [NSRC-1:0] req_q_r;
    logic [NSRC-1:0] pending_r, pending_nxt_s;
    logic            irq_valid_r, irq_valid_nxt_s;
    logic [ID_W-1:0] irq_id_r, irq_id_nxt_s;
    logic [CNT_W-1:0] lost_cnt_r, lost_cnt_nxt_s;

    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] cand_s;
    logic [NSRC-1:0] clr_s;
    logic [ID_W-1:0] enc_id_s;
    logic            lost_any_s;

    assign rise_s = bus.req & ~req_q_r;
    // Mask is applied combinationally so a change is seen on the same edge.
    assign cand_s = pending_r & ~bus.mask;

    pri_enc4 u_pri_enc4 (
        .cand (cand_s),
        .id   (enc_id_s)
    );

    // FSM next state, presented id, valid and the ack-driven clear mask.
    always_comb begin
        state_nxt_s     = state_r;
        irq_id_nxt_s    = irq_id_r;
        irq_valid_nxt_s = 1'b0;
        clr_s           = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                if (cand_s != 4'b0000) begin
                    state_nxt_s     = ST_PRESENT;
                    irq_id_nxt_s    = enc_id_s;
                    irq_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                // No preemption and no retraction: only ack leaves PRESENT.
                if (bus.ack) begin
                    clr_s           = id_to_onehot(irq_id_r);
                    state_nxt_s     = ST_GAP;
                    irq_valid_nxt_s = 1'b0;
                end else begin
                    irq_valid_nxt_s = 1'b1;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pending update (set beats clear) and saturating lost-request count.
    always_comb begin
        pending_nxt_s  = (pending_r & ~clr_s) | rise_s;
        lost_any_s     = |(rise_s & pending_r & ~clr_s);
        lost_cnt_nxt_s = lost_cnt_r;
        if (lost_any_s && !(&lost_cnt_r)) begin
            lost_cnt_nxt_s = lost_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            lost_cnt_nxt_s = lost_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_q_r     <= 4'b0000;
            pending_r   <= 4'b0000;
            irq_valid_r <= 1'b0;
            irq_id_r    <= 2'b00;
            lost_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            req_q_r     <= bus.req;
            pending_r   <= pending_nxt_s;
            irq_valid_r <= irq_valid_nxt_s;
            irq_id_r    <= irq_id_nxt_s;
            lost_cnt_r  <= lost_cnt_nxt_s;
        end
    end

    assign bus.irq_valid = irq_valid_r;
    assign bus.irq_id    = irq_id_r;
    assign bus.pending   = pending_r;
    assign lost_cnt      = lost_cnt_r;

endmodule

// File: tb/tb_irq_ctrl4.sv
// tb_irq_ctrl4: scenario bench for irq_ctrl4. Two instances share stimulus:
// one with the default counter width, one with CNT_W=2 for saturation.
// Expected grant ids are queued when requests are driven and popped when a
// grant appears.
module tb_irq_ctrl4;
    import irq_ctrl4_pkg::*;

    logic clk;
    logic rst_n;
    logic [7:0] lost8;
    logic [1:0] lost2;
    int n_checks;
    int n_fail;
    int exp_q[$];

    irq_ctrl4_if bus();
    irq_ctrl4_if bus2();

    assign bus2.req  = bus.req;
    assign bus2.mask = bus.mask;
    assign bus2.ack  = bus.ack;

    irq_ctrl4 #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .lost_cnt(lost8));
    irq_ctrl4 #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .lost_cnt(lost2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop the next expected grant id and compare it with the presented one.
    task automatic check_grant(input string name);
        logic [1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got grant id %0d, required none queued", name, bus.irq_id);
        end else begin
            e = 2'(exp_q.pop_front());
            if (bus.irq_valid !== 1'b1 || bus.irq_id !== e) begin
                n_fail++;
                $display("FAIL %s: got valid=%b id=%0d, required valid=1 id=%0d",
                         name, bus.irq_valid, bus.irq_id, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.mask = 4'b0000;
        bus.ack  = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.irq_valid, bus.irq_id, bus.pending, lost8, lost2} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b id=%0d p=%b l8=%0d l2=%0d, required all 0",
                     bus.irq_valid, bus.irq_id, bus.pending, lost8, lost2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b p=%b, required v=0 p=0000",
                     bus.irq_valid, bus.pending);
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        exp_q.push_back(2);
        step();
        bus.req = 4'b0000;
        n_checks++;
        if (bus.pending !== 4'b0100 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: got p=%b v=%b, required p=0100 v=0",
                     bus.pending, bus.irq_valid);
        end
        step();
        check_grant("single_grant");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.pending !== 4'b0000 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got p=%b v=%b, required p=0000 v=0",
                     bus.pending, bus.irq_valid);
        end
        step();
        step();
        n_checks++;
        if (bus.irq_valid !== 1'b0 || bus.irq_id !== 2'b10) begin
            n_fail++;
            $display("FAIL single_idle: got v=%b id=%0d, required v=0 id=2",
                     bus.irq_valid, bus.irq_id);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pend_exp [4];
        pend_exp[0] = 4'b1011;
        pend_exp[1] = 4'b0011;
        pend_exp[2] = 4'b0001;
        pend_exp[3] = 4'b0000;
        bus.req = 4'b1011;
        exp_q.push_back(3);
        exp_q.push_back(1);
        exp_q.push_back(0);
        step();
        bus.req = 4'b0000;
        step();
        for (int i = 0; i < 3; i++) begin
            check_grant("b2b_grant");
            n_checks++;
            if (bus.pending !== pend_exp[i]) begin
                n_fail++;
                $display("FAIL b2b_pend_before: got %b, required %b", bus.pending, pend_exp[i]);
            end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
            n_checks++;
            if (bus.pending !== pend_exp[i+1] || bus.irq_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_after_ack: got p=%b v=%b, required p=%b v=0",
                         bus.pending, bus.irq_valid, pend_exp[i+1]);
            end
            step();
            n_checks++;
            if (bus.irq_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap: got v=%b, required v=0", bus.irq_valid);
            end
            step();
        end
        n_checks++;
        if (bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: got v=%b, required v=0", bus.irq_valid);
        end
    endtask

    task automatic test_mask();
        bus.mask = 4'b1000;
        bus.req  = 4'b1001;
        exp_q.push_back(0);
        step();
        bus.req = 4'b0000;
        step();
        check_grant("mask_grant0");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        step();
        // Ack while idle must not clear anything.
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.pending !== 4'b1000 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_held: got p=%b v=%b, required p=1000 v=0",
                     bus.pending, bus.irq_valid);
        end
        bus.mask = 4'b0000;
        exp_q.push_back(3);
        step();
        check_grant("mask_unmask_grant3");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_checks++;
        if (bus.pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL mask_cleared: got p=%b, required p=0000", bus.pending);
        end
        step();
        step();
    endtask

    task automatic test_no_preempt();
        bus.req = 4'b0010;
        exp_q.push_back(1);
        step();
        bus.req = 4'b0000;
        step();
        check_grant("nopre_grant1");
        bus.req = 4'b1000;
        exp_q.push_back(3);
        step();
        bus.req = 4'b0000;
        step();
        n_checks++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b01 || bus.pending !== 4'b1010) begin
            n_fail++;
            $display("FAIL nopre_hold: got v=%b id=%0d p=%b, required v=1 id=1 p=1010",
                     bus.irq_valid, bus.irq_id, bus.pending);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        n_checks++;
        if (bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nopre_gap: got v=%b, required v=0", bus.irq_valid);
        end
        step();
        check_grant("nopre_grant3");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_lost();
        bus.mask = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            bus.req = 4'b0100;
            step();
            bus.req = 4'b0000;
            step();
        end
        n_checks++;
        if (lost8 !== 8'd2 || lost2 !== 2'd2) begin
            n_fail++;
            $display("FAIL lost_three: got l8=%0d l2=%0d, required 2 and 2", lost8, lost2);
        end
        for (int i = 0; i < 6; i++) begin
            bus.req = 4'b0100;
            step();
            bus.req = 4'b0000;
            step();
        end
        n_checks++;
        if (lost8 !== 8'd8 || lost2 !== 2'd3) begin
            n_fail++;
            $display("FAIL lost_saturate: got l8=%0d l2=%0d, required 8 and 3", lost8, lost2);
        end
        bus.mask = 4'b0000;
        exp_q.push_back(2);
        step();
        check_grant("lost_grant2");
        // New edge on the source being acked: set wins and is not counted.
        bus.ack = 1'b1;
        bus.req = 4'b0100;
        exp_q.push_back(2);
        step();
        bus.ack = 1'b0;
        bus.req = 4'b0000;
        n_checks++;
        if (bus.pending !== 4'b0100 || lost8 !== 8'd8 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_set_wins: got p=%b l8=%0d v=%b, required p=0100 l8=8 v=0",
                     bus.pending, lost8, bus.irq_valid);
        end
        step();
        step();
        check_grant("lost_regrant2");
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001;
        exp_q.push_back(0);
        step();
        step();
        check_grant("rstmid_grant0");
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.irq_valid, bus.irq_id, bus.pending, lost8, lost2} !== 17'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b id=%0d p=%b l8=%0d l2=%0d, required all 0",
                     bus.irq_valid, bus.irq_id, bus.pending, lost8, lost2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.pending !== 4'b0001 || bus.irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_reset_edge: got p=%b v=%b, required p=0001 v=0",
                     bus.pending, bus.irq_valid);
        end
        exp_q.push_back(0);
        step();
        check_grant("rstmid_regrant0");
        bus.req = 4'b0000;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_no_preempt();
        test_lost();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d grants outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
